spi_master_ctrl: RTL

- Mode-0 SPI master transaction sequencer (CPOL=0, CPHA=0).
- Derives SCLK from the system clock with a programmable half-period counter.
- Sequences chip-select setup, DATA_W-bit full-duplex shift and chip-select hold, with a start/busy/done handshake to the host logic.
- Replaces the free-running divider tap as the SCLK source for the SPI datapath.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_clk_tick.sv | 39 +++
 rtl/spi_master_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_pkg                                                         |
// | Purpose  : Shared types, defaults and latency helper for the SPI master.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam int c_DEF_DATA_W  = 8;
    localparam int c_DEF_CLK_DIV = 4;

    // Clock cycles from the accept edge to the done edge.
    function automatic int spi_latency(input int data_w, input int clk_div);
        return clk_div * (2 * data_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_clk_tick                                                    |
// | Purpose  : Half-period counter; emits a 1-cycle tick every CLK_DIV cycles. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_clk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign tick = en && (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_master_ctrl                                                 |
// | Purpose  : Mode-0 SPI master sequencer: CS setup, MSB-first shift, CS hold.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int CLK_DIV = c_DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int c_BIT_W = $clog2(DATA_W + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);

    spi_state_t          r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_tx_sh, w_tx_sh_nxt;
    logic [DATA_W-1:0]   r_rx_sh, w_rx_sh_nxt;
    logic [DATA_W-1:0]   r_rx_data, w_rx_data_nxt;
    logic [c_BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic                r_sclk, w_sclk_nxt;
    logic                r_cs_n, w_cs_n_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                w_tick;
    logic                w_last_bit;

    spi_clk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (r_state != IDLE),
        .clr  (r_state == IDLE),
        .tick (w_tick)
    );

    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SETUP;
            SETUP:   if (w_tick) w_state_nxt = XFER;
            XFER:    if (w_tick && r_sclk && w_last_bit) w_state_nxt = HOLD;
            HOLD:    if (w_tick) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Each tick in XFER toggles sclk: a rise samples miso, a fall advances mosi.
    always_comb begin
        w_tx_sh_nxt   = r_tx_sh;
        w_rx_sh_nxt   = r_rx_sh;
        w_rx_data_nxt = r_rx_data;
        w_bit_cnt_nxt = r_bit_cnt;
        w_sclk_nxt    = r_sclk;
        w_cs_n_nxt    = r_cs_n;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_tx_sh_nxt   = tx_data;
                    w_rx_sh_nxt   = '0;
                    w_bit_cnt_nxt = '0;
                    w_sclk_nxt    = 1'b0;
                    w_cs_n_nxt    = 1'b0;
                    w_busy_nxt    = 1'b1;
                end
            end
            SETUP: begin
                if (w_tick) begin
                    w_sclk_nxt  = 1'b1;
                    w_rx_sh_nxt = {r_rx_sh[DATA_W-2:0], miso};
                end
            end
            XFER: begin
                if (w_tick) begin
                    if (r_sclk) begin
                        w_sclk_nxt    = 1'b0;
                        w_bit_cnt_nxt = r_bit_cnt + c_BIT_W'(1);
                        if (!w_last_bit) begin
                            w_tx_sh_nxt = {r_tx_sh[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        w_sclk_nxt  = 1'b1;
                        w_rx_sh_nxt = {r_rx_sh[DATA_W-2:0], miso};
                    end
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_cs_n_nxt    = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_rx_data_nxt = r_rx_sh;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tx_sh   <= w_tx_sh_nxt;
            r_rx_sh   <= w_rx_sh_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_sclk    <= w_sclk_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // The MSB of the transmit shifter is the live mosi bit.
    assign mosi    = r_tx_sh[DATA_W-1];
    assign sclk    = r_sclk;
    assign cs_n    = r_cs_n;
    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;

endmodule
`default_nettype wire
